// File: rtl/cpu_timer.sv
// SM83 DIV/TIMA/TMA/TAC timer block, bus responder at FF04-FF07.
// Runs on every T-cycle; register writes commit on the M-cycle's last T-cycle.
module cpu_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int          RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_tick,
  input  logic [15:0] mem_addr,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_select,
  output logic        irq_timer
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  dly, dly_nx;
  logic [15:0] div_ctr;
  logic [7:0]  tima, tima_nx;
  logic [7:0]  tma, tma_nx;
  logic [2:0]  tac;
  logic        sig, sig_d, div_bit;
  logic        inc, reload, irq_nx;
  logic [15:0] rel;
  logic [1:0]  off;
  logic        hit, wr;
  logic        wr_div, wr_tima, wr_tma, wr_tac;

  assign rel  = mem_addr - BASE_ADDR;
  assign off  = rel[1:0];
  assign hit  = (rel[15:2] == 14'd0);
  assign wr   = m_tick & mem_write_enable & hit;

  assign wr_div  = wr & (off == 2'd0);
  assign wr_tima = wr & (off == 2'd1);
  assign wr_tma  = wr & (off == 2'd2);
  assign wr_tac  = wr & (off == 2'd3);

  assign mem_select = mem_read_enable & hit;

  always_comb begin
    mem_data_out = 8'hFF;
    if (mem_select) begin
      case (off)
        2'd0: mem_data_out = div_ctr[15:8];
        2'd1: mem_data_out = tima;
        2'd2: mem_data_out = tma;
        2'd3: mem_data_out = {5'b11111, tac};
        default: mem_data_out = 8'hFF;
      endcase
    end
  end

  always_comb begin
    case (tac[1:0])
      2'b00: div_bit = div_ctr[9];
      2'b01: div_bit = div_ctr[3];
      2'b10: div_bit = div_ctr[5];
      2'b11: div_bit = div_ctr[7];
      default: div_bit = 1'b0;
    endcase
  end

  // DIV/TAC writes move sig too, so they can fake a falling edge
  assign sig    = tac[2] & div_bit;
  assign inc    = sig_d & ~sig;
  assign tma_nx = wr_tma ? mem_data_in : tma;
  assign reload = (state == PENDING) &&
                  (dly == 2'(RELOAD_DELAY - 1));

  always_comb begin
    state_nx = state;
    dly_nx   = dly;
    tima_nx  = tima;
    irq_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_tima) begin
          tima_nx = mem_data_in;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_nx  = 8'h00;
            state_nx = PENDING;
            dly_nx   = 2'd0;
          end else begin
            tima_nx = tima + 8'd1;
          end
        end
      end
      PENDING: begin
        if (reload) begin
          tima_nx  = tma_nx;
          irq_nx   = 1'b1;
          state_nx = IDLE;
          dly_nx   = 2'd0;
        end else if (wr_tima) begin
          tima_nx  = mem_data_in;
          state_nx = IDLE;
          dly_nx   = 2'd0;
        end else begin
          dly_nx = dly + 2'd1;
          if (inc) tima_nx = tima + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_ctr   <= 16'd0;
      tima      <= 8'd0;
      tma       <= 8'd0;
      tac       <= 3'd0;
      state     <= IDLE;
      dly       <= 2'd0;
      sig_d     <= 1'b0;
      irq_timer <= 1'b0;
    end else begin
      div_ctr   <= wr_div ? 16'd0 : div_ctr + 16'd1;
      tima      <= tima_nx;
      tma       <= tma_nx;
      if (wr_tac) tac <= mem_data_in[2:0];
      state     <= state_nx;
      dly       <= dly_nx;
      sig_d     <= sig;
      irq_timer <= irq_nx;
    end
  end

endmodule

// File: tb/tb_cpu_timer.sv
// Bench for cpu_timer: cycle model of the timer rules plus directed
// scenarios with literal expectations.
module tb_cpu_timer;

  localparam int RELOAD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_tick;
  logic [15:0] mem_addr;
  logic        re, we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        sel;
  logic        irq;

  cpu_timer dut (
    .clk              (clk),
    .reset            (reset),
    .m_tick           (m_tick),
    .mem_addr         (mem_addr),
    .mem_read_enable  (re),
    .mem_write_enable (we),
    .mem_data_in      (din),
    .mem_data_out     (dout),
    .mem_select       (sel),
    .irq_timer        (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_cnt = 0;
  bit chk_en = 0;

  int m_div, m_tima, m_tma, m_tac, m_rem, m_irq;
  bit m_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'hFF04) && (a <= 16'hFF07);
  endfunction

  function automatic int exp_data();
    if (!(re && in_win(mem_addr))) return 8'hFF;
    case (mem_addr)
      16'hFF04: return (m_div >> 8) & 8'hFF;
      16'hFF05: return m_tima;
      16'hFF06: return m_tma;
      default:  return 8'hF8 | m_tac;
    endcase
  endfunction

  task automatic model_step();
    int sh, tma_n;
    bit sig, inc, w;
    m_irq = 0;
    if (reset) begin
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_rem = 0; m_prev = 0;
    end else begin
      case (m_tac & 3)
        0: sh = 9;
        1: sh = 3;
        2: sh = 5;
        default: sh = 7;
      endcase
      sig = ((m_tac >> 2) & 1) != 0 && ((m_div >> sh) & 1) != 0;
      inc = m_prev && !sig;
      w = m_tick && we && in_win(mem_addr);
      tma_n = (w && mem_addr == 16'hFF06) ? int'(din) : m_tma;
      if (m_rem == 1) begin
        m_tima = tma_n;
        m_irq = 1;
        m_rem = 0;
      end else begin
        if (m_rem > 1) m_rem--;
        if (w && mem_addr == 16'hFF05) begin
          m_tima = din;
          m_rem = 0;
        end else if (inc) begin
          if (m_tima == 255) begin
            m_tima = 0;
            m_rem = RELOAD;
          end else begin
            m_tima++;
          end
        end
      end
      m_tma = tma_n;
      if (w && mem_addr == 16'hFF07) m_tac = din & 7;
      m_div = (w && mem_addr == 16'hFF04) ? 0 : (m_div + 1) & 16'hFFFF;
      m_prev = sig;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sel", sel, (re && in_win(mem_addr)) ? 1 : 0);
      chk("rdata", dout, exp_data());
      chk("irq", irq, m_irq);
      if (irq === 1'b1) irq_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    mem_addr = a; din = d; we = 1; m_tick = 1; re = 1;
    step();
    we = 0; m_tick = 0; mem_addr = 16'hFF05;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a,
                        input logic [7:0] e);
    mem_addr = a; re = 1;
    @(negedge clk);
    chk(nm, dout, e);
    step();
    mem_addr = 16'hFF05;
  endtask

  task automatic wait_rem(input int r, output bit found);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_rem == r) found = 1;
      else step();
    end
  endtask

  initial begin
    bit found, saw_ff, seen;
    int c0;
    reset = 1; m_tick = 0; we = 0; re = 1; din = 0;
    mem_addr = 16'hFF04;
    step(); step();
    chk_en = 1;
    reset = 0;

    // 1: reset state and free-running divider
    repeat (256) step();
    rd_chk("div_256", 16'hFF04, 8'h01);
    rd_chk("tima_rst", 16'hFF05, 8'h00);
    rd_chk("tma_rst", 16'hFF06, 8'h00);
    rd_chk("tac_rst", 16'hFF07, 8'hF8);
    chk("no_irq_idle", irq_cnt, 0);

    // 2: overflow, delayed reload and one-clock irq
    wr(16'hFF07, 8'h05);
    wr(16'hFF06, 8'h42);
    wr(16'hFF05, 8'hFE);
    saw_ff = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dout === 8'hFF) saw_ff = 1;
      if (irq === 1'b1) found = 1;
      else step();
    end
    chk("t2_irq", found, 1);
    chk("t2_reload", dout, 8'h42);
    chk("t2_saw_ff", saw_ff, 1);
    step();
    @(negedge clk);
    chk("t2_irq_1clk", irq, 0);
    step();

    // 3: TIMA write inside the pending window cancels the reload
    wr(16'hFF05, 8'hFE);
    seen = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (dout === 8'hFF) seen = 1;
      if (seen && dout === 8'h00) found = 1;
      step();
    end
    chk("t3_wait", found, 1);
    wr(16'hFF05, 8'h10);
    @(negedge clk);
    chk("t3_tima_wr", dout, 8'h10);
    c0 = irq_cnt;
    repeat (8) step();
    chk("t3_no_irq", irq_cnt - c0, 0);
    rd_chk("t3_no_reload", 16'hFF05, 8'h10);

    // 4: DIV write with the tick bit high fakes a falling edge
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if ((m_div & 15) == 8) found = 1;
      else step();
    end
    chk("t4_wait_hi", found, 1);
    wr(16'hFF05, 8'h20);
    wr(16'hFF04, 8'h5A);
    step(); step();
    rd_chk("t4_glitch", 16'hFF05, 8'h21);
    rd_chk("t4_div_clr", 16'hFF04, 8'h00);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if ((m_div & 15) == 0) found = 1;
      else step();
    end
    chk("t4_wait_lo", found, 1);
    wr(16'hFF05, 8'h20);
    wr(16'hFF04, 8'h00);
    step(); step();
    rd_chk("t4_no_glitch", 16'hFF05, 8'h20);

    // 5: TMA written on the reload clock is the value loaded
    wr(16'hFF05, 8'hFE);
    wait_rem(1, found);
    chk("t5_wait", found, 1);
    wr(16'hFF06, 8'h77);
    @(negedge clk);
    chk("t5_irq", irq, 1);
    chk("t5_tma_same", dout, 8'h77);
    step();
    wr(16'hFF05, 8'hFE);
    wait_rem(1, found);
    chk("t5_wait2", found, 1);
    wr(16'hFF05, 8'h33);
    @(negedge clk);
    chk("t5_irq2", irq, 1);
    chk("t5_tima_wr_lost", dout, 8'h77);
    step();

    // 6: reset mid-pending, then an out-of-window read
    wr(16'hFF05, 8'hFE);
    wait_rem(3, found);
    chk("t6_wait", found, 1);
    reset = 1;
    step();
    reset = 0;
    c0 = irq_cnt;
    repeat (8) step();
    chk("t6_no_irq", irq_cnt - c0, 0);
    rd_chk("t6_tima0", 16'hFF05, 8'h00);
    mem_addr = 16'hFF08; re = 1;
    @(negedge clk);
    chk("t6_sel_ff08", sel, 0);
    chk("t6_data_ff08", dout, 8'hFF);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
